// File: rtl/alu_md_pkg.sv
// Shared op codes, FSM state encoding and decode helpers for the
// execute-stage ALU with its iterative multiply/divide engine.
package alu_md_pkg;

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_OR     = 5'b00001;
  localparam logic [4:0] OP_ADD    = 5'b00010;
  localparam logic [4:0] OP_XOR    = 5'b00011;
  localparam logic [4:0] OP_SLL    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SUB    = 5'b00110;
  localparam logic [4:0] OP_SRA    = 5'b00111;
  localparam logic [4:0] OP_SLT    = 5'b01010;
  localparam logic [4:0] OP_SLTU   = 5'b01011;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} md_state_t;

  // Width-independent selector for the divide special-case result.
  typedef enum logic [1:0] {SP_ONES, SP_DIVIDEND, SP_MIN, SP_ZERO} md_special_t;

  function automatic logic is_md_op(input logic [4:0] ctrl);
    return ctrl[4];
  endfunction

  // Divide by zero: quotient all ones, remainder = dividend.
  // Signed overflow: quotient = MIN, remainder = 0.
  function automatic md_special_t md_special(input logic div_zero, input logic is_rem);
    if (div_zero) return is_rem ? SP_DIVIDEND : SP_ONES;
    return is_rem ? SP_ZERO : SP_MIN;
  endfunction

endpackage

// File: rtl/alu_md_unit_md_iter_core.sv
// One-bit-per-cycle shift-add multiplier / restoring divider on unsigned
// magnitudes; step results are exposed so the final step can be captured directly.
module md_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            sys_clk,
  input  logic            sys_arstn,
  input  logic            start,
  input  logic            run,
  input  logic            div_mode_in,
  input  logic [XLEN-1:0] mag_a,
  input  logic [XLEN-1:0] mag_b,
  output logic            done,
  output logic [XLEN-1:0] step_hi,
  output logic [XLEN-1:0] step_lo
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic [CW-1:0]   cnt_q;
  logic            div_mode_q;

  logic [XLEN:0]   mul_sum, div_trial, div_diff;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_trial = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, b_q};
    if (div_mode_q) begin
      step_hi = div_diff[XLEN] ? div_trial[XLEN-1:0] : div_diff[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign done = run & (cnt_q == '0);

  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      hi_q       <= '0;
      lo_q       <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      div_mode_q <= 1'b0;
    end else if (start) begin
      hi_q       <= '0;
      lo_q       <= mag_a;
      b_q        <= mag_b;
      cnt_q      <= CW'(XLEN - 1);
      div_mode_q <= div_mode_in;
    end else if (run) begin
      hi_q <= step_hi;
      lo_q <= step_lo;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/alu_md_unit.sv
// Execute-stage ALU: combinational integer ops plus an iterative RV32M/RV64M
// multiply/divide sequenced by a three-state FSM that stalls through hold.
module alu_md_unit
  import alu_md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            sys_clk,
  input  logic            sys_arstn,
  input  logic            flush,
  input  logic            op_valid,
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] data_in_0,
  input  logic [XLEN-1:0] data_in_1,
  output logic [XLEN-1:0] result,
  output logic [1:0]      flag_result,
  output logic            result_valid,
  output logic            hold
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t       state, state_nxt;
  logic [XLEN-1:0] alu_val, res_q, mag_a, mag_b, fixed_val, special_val;
  logic [XLEN-1:0] core_hi, core_lo;
  logic [SHW-1:0]  shamt;
  logic            accept, fast, div_zero, div_ovf, core_done;
  logic            op_div, op_rem, op_mulhi, a_sgn, b_sgn, a_neg, b_neg;
  logic            neg_q, div_q, rem_q, mulhi_q;

  assign shamt = data_in_1[SHW-1:0];

  always_comb begin
    alu_val = data_in_0 + data_in_1;
    case (alu_ctrl)
      OP_AND:  alu_val = data_in_0 & data_in_1;
      OP_OR:   alu_val = data_in_0 | data_in_1;
      OP_XOR:  alu_val = data_in_0 ^ data_in_1;
      OP_SLL:  alu_val = data_in_0 << shamt;
      OP_SRL:  alu_val = data_in_0 >> shamt;
      OP_SUB:  alu_val = data_in_0 - data_in_1;
      OP_SRA:  alu_val = $signed(data_in_0) >>> shamt;
      OP_SLT:  alu_val = {{(XLEN-1){1'b0}}, $signed(data_in_0) < $signed(data_in_1)};
      OP_SLTU: alu_val = {{(XLEN-1){1'b0}}, data_in_0 < data_in_1};
      default: alu_val = data_in_0 + data_in_1;
    endcase
  end

  // Decode and magnitude conversion for the op being accepted.
  always_comb begin
    op_rem   = (alu_ctrl == OP_REM) | (alu_ctrl == OP_REMU);
    op_div   = (alu_ctrl == OP_DIV) | (alu_ctrl == OP_DIVU) | op_rem;
    op_mulhi = (alu_ctrl == OP_MULH) | (alu_ctrl == OP_MULHSU) | (alu_ctrl == OP_MULHU);
    b_sgn    = (alu_ctrl == OP_MULH) | (alu_ctrl == OP_DIV) | (alu_ctrl == OP_REM);
    a_sgn    = b_sgn | (alu_ctrl == OP_MULHSU);
    a_neg    = a_sgn & data_in_0[XLEN-1];
    b_neg    = b_sgn & data_in_1[XLEN-1];
    mag_a    = a_neg ? -data_in_0 : data_in_0;
    mag_b    = b_neg ? -data_in_1 : data_in_1;
    div_zero = op_div & (data_in_1 == '0);
    div_ovf  = op_div & a_sgn & (data_in_0 == MIN_VAL) & (data_in_1 == '1);
    fast     = div_zero | div_ovf;
    accept   = (state == ST_IDLE) & op_valid & is_md_op(alu_ctrl) & ~flush;
    case (md_special(div_zero, op_rem))
      SP_ONES:     special_val = '1;
      SP_DIVIDEND: special_val = data_in_0;
      SP_MIN:      special_val = MIN_VAL;
      default:     special_val = '0;
    endcase
  end

  md_iter_core #(.XLEN(XLEN)) u_core (
    .sys_clk     (sys_clk),
    .sys_arstn   (sys_arstn),
    .start       (accept & ~fast),
    .run         ((state == ST_BUSY) & ~flush),
    .div_mode_in (op_div),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .done        (core_done),
    .step_hi     (core_hi),
    .step_lo     (core_lo)
  );

  // Sign fix-up works on the final step output so DONE follows the last BUSY cycle directly.
  always_comb begin
    logic [2*XLEN-1:0] prod;
    prod = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};
    if (div_q)        fixed_val = neg_q ? -(rem_q ? core_hi : core_lo) : (rem_q ? core_hi : core_lo);
    else if (mulhi_q) fixed_val = prod[2*XLEN-1:XLEN];
    else              fixed_val = prod[XLEN-1:0];
  end

  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      res_q   <= '0;
      neg_q   <= 1'b0;
      div_q   <= 1'b0;
      rem_q   <= 1'b0;
      mulhi_q <= 1'b0;
    end else if (accept) begin
      neg_q   <= op_rem ? a_neg : (a_neg ^ b_neg);
      div_q   <= op_div;
      rem_q   <= op_rem;
      mulhi_q <= op_mulhi;
      if (fast) res_q <= special_val;
    end else if (core_done) begin
      res_q <= fixed_val;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_nxt = fast ? ST_DONE : ST_BUSY;
        ST_BUSY: if (core_done) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    hold         = ~flush & (((state == ST_IDLE) & op_valid & alu_ctrl[4]) | (state == ST_BUSY));
    result_valid = (state == ST_DONE) | (op_valid & ~alu_ctrl[4]);
    result       = (state == ST_DONE) ? res_q : alu_val;
    flag_result  = {result == '0, result[XLEN-1]};
  end

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed self-checking bench for alu_md_unit at XLEN = 32.
module tb_alu_md_unit;

  localparam logic [4:0] C_AND = 5'b00000, C_ADD = 5'b00010, C_XOR = 5'b00011;
  localparam logic [4:0] C_SLL = 5'b00100, C_SUB = 5'b00110, C_SRA = 5'b00111;
  localparam logic [4:0] C_SLT = 5'b01010, C_SLTU = 5'b01011;
  localparam logic [4:0] C_MUL = 5'b10000, C_MULH = 5'b10001, C_MULHSU = 5'b10010;
  localparam logic [4:0] C_MULHU = 5'b10011, C_DIV = 5'b10100, C_DIVU = 5'b10101;
  localparam logic [4:0] C_REM = 5'b10110, C_REMU = 5'b10111;

  logic        sys_clk, sys_arstn, flush, op_valid;
  logic [4:0]  alu_ctrl;
  logic [31:0] data_in_0, data_in_1, result;
  logic [1:0]  flag_result;
  logic        result_valid, hold;

  int total = 0;
  int bad   = 0;

  alu_md_unit #(.XLEN(32)) dut (
    .sys_clk      (sys_clk),
    .sys_arstn    (sys_arstn),
    .flush        (flush),
    .op_valid     (op_valid),
    .alu_ctrl     (alu_ctrl),
    .data_in_0    (data_in_0),
    .data_in_1    (data_in_1),
    .result       (result),
    .flag_result  (flag_result),
    .result_valid (result_valid),
    .hold         (hold)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic alu1(input string tag, input logic [4:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input logic [1:0] fexp);
    op_valid = 1'b1; alu_ctrl = c; data_in_0 = a; data_in_1 = b;
    #1;
    chk({tag, "_res"}, result, exp);
    chk({tag, "_flag"}, 32'(flag_result), 32'(fexp));
    chk({tag, "_hold"}, 32'(hold), 32'd0);
    chk({tag, "_rv"}, 32'(result_valid), 32'd1);
    tick();
  endtask

  // Counts hold-high cycles from acceptance, then checks the DONE result.
  task automatic md_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int hold_exp);
    int n;
    n = 0;
    op_valid = 1'b1; alu_ctrl = c; data_in_0 = a; data_in_1 = b;
    #1;
    while (hold && n < 100) begin
      n++;
      tick();
    end
    chk({tag, "_holdcyc"}, n, hold_exp);
    chk({tag, "_rv"}, 32'(result_valid), 32'd1);
    chk({tag, "_res"}, result, exp);
    data_in_0 = ~a; data_in_1 = a;
    #1;
    chk({tag, "_res_stable"}, result, exp);
    op_valid = 1'b0;
    tick();
  endtask

  initial begin
    sys_arstn = 1'b0; flush = 1'b0; op_valid = 1'b0;
    alu_ctrl = '0; data_in_0 = '0; data_in_1 = '0;
    #2;
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_rv_idle", 32'(result_valid), 32'd0);
    op_valid = 1'b1; alu_ctrl = C_ADD;
    #1;
    chk("rst_rv_single", 32'(result_valid), 32'd1);
    op_valid = 1'b0;
    @(negedge sys_clk) sys_arstn = 1'b1;
    tick();

    alu1("add_ovf", C_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 2'b01);
    alu1("sra",     C_SRA,  32'h80000000, 32'h4,        32'hF8000000, 2'b01);
    alu1("sltu",    C_SLTU, 32'h1,        32'hFFFFFFFF, 32'h1,        2'b00);
    alu1("slt",     C_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        2'b00);
    alu1("sub",     C_SUB,  32'h5,        32'h7,        32'hFFFFFFFE, 2'b01);
    alu1("xor_z",   C_XOR,  32'h1234ABCD, 32'h1234ABCD, 32'h0,        2'b10);
    alu1("sll",     C_SLL,  32'h1,        32'h3F,       32'h80000000, 2'b01);
    alu1("and",     C_AND,  32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, 2'b00);

    md_op("mulh",   C_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
    md_op("mulhu",  C_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    md_op("mulhsu", C_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    md_op("mul_neg", C_MUL,   32'hFFFFFFFD, 32'h5,        32'hFFFFFFF1, 33);
    md_op("div",    C_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33);
    md_op("rem",    C_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33);
    md_op("divu",   C_DIVU,   32'd100,      32'd7,        32'd14,       33);
    md_op("remu",   C_REMU,   32'd100,      32'd7,        32'd2,        33);
    md_op("div0",   C_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
    md_op("rem0",   C_REM,    32'd5,        32'd0,        32'd5,        1);
    md_op("div_ovf", C_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    md_op("rem_ovf", C_REM,   32'h80000000, 32'hFFFFFFFF, 32'h0,        1);

    // Flush ten cycles into a DIVU.
    op_valid = 1'b1; alu_ctrl = C_DIVU; data_in_0 = 32'd1000; data_in_1 = 32'd7;
    repeat (10) tick();
    chk("flush_pre_hold", 32'(hold), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_hold", 32'(hold), 32'd0);
    tick();
    flush = 1'b0; op_valid = 1'b0;
    #1;
    chk("flush_idle_hold", 32'(hold), 32'd0);
    chk("flush_idle_rv", 32'(result_valid), 32'd0);
    md_op("divu_after_flush", C_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Reset in the middle of a MUL.
    op_valid = 1'b1; alu_ctrl = C_MUL; data_in_0 = 32'd123; data_in_1 = 32'd456;
    repeat (5) tick();
    chk("rstmid_pre_hold", 32'(hold), 32'd1);
    sys_arstn = 1'b0; op_valid = 1'b0;
    #1;
    chk("rstmid_hold", 32'(hold), 32'd0);
    chk("rstmid_rv", 32'(result_valid), 32'd0);
    @(negedge sys_clk) sys_arstn = 1'b1;
    tick();
    md_op("mul_after_rst", C_MUL, 32'd6, 32'd7, 32'd42, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
